// File: rtl/cordic_rotate_arbiter.sv
// Round-robin arbiter that shares one CORDIC rotate core between NUM_REQ requesters.
// Optional WAIT watchdog is enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_rotate_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 7,
  parameter int unsigned ANGLE_WIDTH    = 22,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_y,
  input  logic [NUM_REQ*ANGLE_WIDTH-1:0] i_angle,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [NUM_REQ-1:0]             o_valid,
  output logic [DATA_WIDTH-1:0]          o_x,
  output logic [DATA_WIDTH-1:0]          o_y,
  output logic                           o_err,
  output logic                           o_busy,
  output logic                           o_core_start,
  output logic [DATA_WIDTH-1:0]          o_core_x,
  output logic [DATA_WIDTH-1:0]          o_core_y,
  output logic [ANGLE_WIDTH-1:0]         o_core_angle,
  input  logic [DATA_WIDTH-1:0]          i_core_x,
  input  logic [DATA_WIDTH-1:0]          i_core_y,
  input  logic                           i_core_done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  logic [DATA_WIDTH-1:0]  x_arr     [NUM_REQ];
  logic [DATA_WIDTH-1:0]  y_arr     [NUM_REQ];
  logic [ANGLE_WIDTH-1:0] angle_arr [NUM_REQ];

  for (genvar r = 0; r < int'(NUM_REQ); r++) begin : g_unpack
    assign x_arr[r]     = i_x[r*DATA_WIDTH +: DATA_WIDTH];
    assign y_arr[r]     = i_y[r*DATA_WIDTH +: DATA_WIDTH];
    assign angle_arr[r] = i_angle[r*ANGLE_WIDTH +: ANGLE_WIDTH];
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   start_q, start_d;
  logic [DATA_WIDTH-1:0]  core_x_q, core_x_d, core_y_q, core_y_d;
  logic [ANGLE_WIDTH-1:0] core_angle_q, core_angle_d;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       cand;
  logic                   found;
`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

  // Round-robin search starting just after the last served requester.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!found && i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    gnt_d        = '0;
    valid_d      = '0;
    x_d          = x_q;
    y_d          = y_q;
    err_d        = 1'b0;
    start_d      = 1'b0;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    core_angle_d = core_angle_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d        = pick;
          core_x_d     = x_arr[pick];
          core_y_d     = y_arr[pick];
          core_angle_d = angle_arr[pick];
          gnt_d[pick]  = 1'b1;
          start_d      = 1'b1;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_done) begin
          x_d            = i_core_x;
          y_d            = i_core_y;
          valid_d[win_q] = 1'b1;
          state_d        = S_DONE;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          x_d            = '0;
          y_d            = '0;
          err_d          = 1'b1;
          valid_d[win_q] = 1'b1;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      win_q        <= '0;
      gnt_q        <= '0;
      valid_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      core_angle_q <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      gnt_q        <= gnt_d;
      valid_q      <= valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      core_angle_q <= core_angle_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign o_gnt        = gnt_q;
  assign o_valid      = valid_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;
  assign o_core_start = start_q;
  assign o_core_x     = core_x_q;
  assign o_core_y     = core_y_q;
  assign o_core_angle = core_angle_q;

endmodule

// File: tb/tb_cordic_rotate_arbiter.sv
// Directed bench for cordic_rotate_arbiter; the core is stubbed by driving i_core_* directly.
module tb_cordic_rotate_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 7;
  localparam int unsigned AW = 22;

  logic            clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_x, i_y;
  logic [N*AW-1:0] i_angle;
  logic [N-1:0]    o_gnt, o_valid;
  logic [DW-1:0]   o_x, o_y;
  logic            o_err, o_busy, o_core_start;
  logic [DW-1:0]   o_core_x, o_core_y;
  logic [AW-1:0]   o_core_angle;
  logic [DW-1:0]   i_core_x, i_core_y;
  logic            i_core_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cordic_rotate_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_x(i_x), .i_y(i_y), .i_angle(i_angle),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_err(o_err), .o_busy(o_busy),
    .o_core_start(o_core_start), .o_core_x(o_core_x), .o_core_y(o_core_y),
    .o_core_angle(o_core_angle), .i_core_x(i_core_x), .i_core_y(i_core_y),
    .i_core_done(i_core_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request, wait for grant, complete the job after 'delay' WAIT cycles, land in IDLE.
  task automatic do_job(input logic [N-1:0] req, input int w, input int delay,
                        input logic [DW-1:0] cx, input logic [DW-1:0] cy, input bit drop);
    logic [N-1:0] eg;
    bit got;
    eg  = N'(1 << w);
    got = 1'b0;
    i_req = req;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (o_gnt != '0) got = 1'b1;
    end
    check("gnt", 64'(o_gnt), 64'(eg));
    check("core_start", 64'(o_core_start), 64'(1'b1));
    check("core_x", 64'(o_core_x), 64'(DW'(i_x >> (w*DW))));
    check("core_angle", 64'(o_core_angle), 64'(AW'(i_angle >> (w*AW))));
    if (drop) i_req = '0;
    repeat (delay) step();
    check("valid_early", 64'(o_valid), 64'(0));
    i_core_done = 1'b1;
    i_core_x    = cx;
    i_core_y    = cy;
    step();
    i_core_done = 1'b0;
    check("valid", 64'(o_valid), 64'(eg));
    check("o_x", 64'(o_x), 64'(cx));
    check("o_y", 64'(o_y), 64'(cy));
    check("err_ok", 64'(o_err), 64'(0));
    step();
    check("valid_pulse", 64'(o_valid), 64'(0));
  endtask

  initial begin
    i_rst = 1'b1; i_req = '0; i_core_done = 1'b0; i_core_x = '0; i_core_y = '0;
    i_x     = {7'h13, 7'h6C, 7'h0A, 7'h21};
    i_y     = {7'h31, 7'h6C, 7'h55, 7'h02};
    i_angle = {22'd12345, 22'd699040, 22'd777, 22'd4096};

    // Reset held with every request pending.
    i_req = 4'b1111;
    repeat (3) step();
    check("rst_gnt", 64'(o_gnt), 64'(0));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_start", 64'(o_core_start), 64'(0));
    check("rst_err", 64'(o_err), 64'(0));
    check("rst_ox", 64'(o_x), 64'(0));
    check("rst_core_x", 64'(o_core_x), 64'(0));
    check("rst_core_angle", 64'(o_core_angle), 64'(0));
    i_rst = 1'b0;
    do_job(4'b1111, 0, 2, 7'h11, 7'h22, 1'b1);

    // Single requester r2, hand-computed operands and result.
    do_job(4'b0100, 2, 16, 7'h05, 7'h65, 1'b1);
    check("t2_core_x", 64'(o_core_x), 64'(7'h6C));
    check("t2_core_y", 64'(o_core_y), 64'(7'h6C));
    check("t2_core_angle", 64'(o_core_angle), 64'(22'd699040));
    check("t2_hold_x", 64'(o_x), 64'(7'h05));

    // Partial request patterns: ptr=2 -> r0; ptr=0 -> r1; ptr=1 -> r3.
    do_job(4'b0101, 0, 1, 7'h01, 7'h02, 1'b1);
    do_job(4'b1010, 1, 3, 7'h03, 7'h04, 1'b1);
    do_job(4'b1001, 3, 2, 7'h7E, 7'h40, 1'b1);

    // All requesting: strict rotation r0..r3 twice.
    for (int j = 0; j < 8; j++)
      do_job(4'b1111, j % 4, 1 + j, DW'(j + 8), DW'(100 - j), 1'b0);
    i_req = '0;

    // Stray done in IDLE and in LAUNCH is ignored.
    step();
    i_core_done = 1'b1;
    step();
    step();
    i_core_done = 1'b0;
    check("t4_idle_valid", 64'(o_valid), 64'(0));
    check("t4_idle_busy", 64'(o_busy), 64'(0));
    i_req = 4'b0010;
    step();
    check("t4_gnt", 64'(o_gnt), 64'(4'b0010));
    i_req = '0;
    i_core_done = 1'b1; i_core_x = 7'h3C; i_core_y = 7'h4D;
    step();
    i_core_done = 1'b0;
    check("t4_launch_valid", 64'(o_valid), 64'(0));
    check("t4_wait_busy", 64'(o_busy), 64'(1));
    step();
    check("t4_still_wait", 64'(o_valid), 64'(0));
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    check("t4_valid", 64'(o_valid), 64'(4'b0010));
    check("t4_ox", 64'(o_x), 64'(7'h3C));
    step();

    // Reset during WAIT aborts the job and restores the pointer.
    i_req = 4'b0010;
    step();
    check("t5_gnt", 64'(o_gnt), 64'(4'b0010));
    i_req = '0;
    step();
    step();
    i_rst = 1'b1;
    #1;
    check("t5_rst_busy", 64'(o_busy), 64'(0));
    check("t5_rst_ox", 64'(o_x), 64'(0));
    check("t5_rst_core_x", 64'(o_core_x), 64'(0));
    step();
    i_rst = 1'b0;
    i_core_done = 1'b1; i_core_x = 7'h55; i_core_y = 7'h66;
    step();
    i_core_done = 1'b0;
    check("t5_no_valid", 64'(o_valid), 64'(0));
    step();
    check("t5_no_valid2", 64'(o_valid), 64'(0));
    do_job(4'b1111, 0, 4, 7'h2A, 7'h6B, 1'b1);

    // Core never completes.
    i_req = 4'b0001;
    step();
    check("t6_gnt", 64'(o_gnt), 64'(4'b0001));
    i_req = '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    repeat (8) step();
    check("t6_no_valid_yet", 64'(o_valid), 64'(0));
    check("t6_busy", 64'(o_busy), 64'(1));
    step();
    check("t6_valid", 64'(o_valid), 64'(4'b0001));
    check("t6_err", 64'(o_err), 64'(1));
    check("t6_ox", 64'(o_x), 64'(0));
    check("t6_oy", 64'(o_y), 64'(0));
    step();
    check("t6_err_pulse", 64'(o_err), 64'(0));
    check("t6_idle", 64'(o_busy), 64'(0));
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    step();
    check("t6_late_done", 64'(o_valid), 64'(0));
`else
    repeat (20) step();
    check("t6_busy", 64'(o_busy), 64'(1));
    check("t6_err", 64'(o_err), 64'(0));
    check("t6_valid", 64'(o_valid), 64'(0));
    check("t6_hold_x", 64'(o_x), 64'(7'h2A));
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("t6_rst_busy", 64'(o_busy), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
